// File: rtl/dht_reader.sv
`default_nettype none
// ============================================================================
// Module   : dht_reader
// Purpose  : DHT11/DHT22 single-wire controller: start pulse, response and
//            40-bit frame timing, decoded bytes with a one-cycle valid strobe.
// Option   : define DHT_CHECKSUM_EN to reject frames with a bad parity byte.
// Revision : 1.0
// ============================================================================
module dht_reader #(
  parameter int CLK_HZ         = 100_000_000,
  parameter int START_US       = 18000,
  parameter int BIT_THRESH_US  = 40,
  parameter int TIMEOUT_US     = 200,
  parameter int AUTO_PERIOD_MS = 0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  inout  wire        DHT_data,
  output logic [7:0] hum_int,
  output logic [7:0] hum_float,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_float,
  output logic [7:0] parity,
  output logic       data_valid,
  output logic       busy,
  output logic       err_timeout,
  output logic       err_chk
);

  localparam int CYC_US    = (CLK_HZ / 1_000_000 < 1) ? 1 : CLK_HZ / 1_000_000;
  localparam int START_CYC = START_US * CYC_US;
  localparam int TO_CYC    = TIMEOUT_US * CYC_US;
  localparam int TH_CYC    = BIT_THRESH_US * CYC_US;
  localparam int CNT_MAX   = (START_CYC > TO_CYC) ? START_CYC : TO_CYC;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int AUTO_CYC  = AUTO_PERIOD_MS * 1000 * CYC_US;
  localparam int AUTO_W    = (AUTO_CYC > 1) ? $clog2(AUTO_CYC) : 1;

  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(CNT_MAX);
  localparam logic [CNT_W-1:0]  START_LAST  = CNT_W'(START_CYC - 1);
  localparam logic [CNT_W-1:0]  TO_LIMIT    = CNT_W'(TO_CYC);
  localparam logic [AUTO_W-1:0] AUTO_RELOAD = AUTO_W'((AUTO_CYC > 0) ? AUTO_CYC - 1 : 0);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [5:0]        bit_cnt_q, bit_cnt_d;
  logic [39:0]       shift_q, shift_d;
  logic [39:0]       frame_q, frame_d;
  logic [2:0]        sync_q, sync_d;
  logic [AUTO_W-1:0] auto_q, auto_d;
  logic              data_valid_q, data_valid_d;
  logic              err_timeout_q, err_timeout_d;
  logic              err_chk_q, err_chk_d;

  logic              rise, fall, timed_out, bit_val, auto_fire, chk_ok;
  logic [CNT_W-1:0]  cnt_inc;

  // sync_q[1] is the synchronised line, sync_q[2] its previous value
  assign rise      = sync_q[1] & ~sync_q[2];
  assign fall      = ~sync_q[1] & sync_q[2];
  assign timed_out = (cnt_q >= TO_LIMIT);
  assign cnt_inc   = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + 1'b1;
  assign bit_val   = (int'(cnt_q) > TH_CYC);
  assign auto_fire = (AUTO_CYC > 0) && (auto_q == '0);

`ifdef DHT_CHECKSUM_EN
  logic [7:0] chk_sum;
  assign chk_sum = shift_q[39:32] + shift_q[31:24] + shift_q[23:16] + shift_q[15:8];
  assign chk_ok  = (chk_sum == shift_q[7:0]);
`else
  assign chk_ok  = 1'b1;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    frame_d       = frame_q;
    sync_d        = {sync_q[1:0], DHT_data};
    auto_d        = auto_q;
    data_valid_d  = 1'b0;
    err_timeout_d = err_timeout_q;
    err_chk_d     = err_chk_q;

    case (state_q)
      S_IDLE: begin
        if (auto_q != '0) auto_d = auto_q - 1'b1;
        if (start || auto_fire) begin
          state_d       = S_START_LOW;
          cnt_d         = '0;
          err_timeout_d = 1'b0;
          err_chk_d     = 1'b0;
        end
      end
      S_START_LOW: begin
        if (cnt_q == START_LAST) begin
          state_d = S_RELEASE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_RELEASE, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH: begin
        cnt_d = cnt_inc;
        if (timed_out) state_d = S_ERROR;
        case (state_q)
          S_RELEASE:   if (fall) begin state_d = S_RESP_LOW;  cnt_d = '0; end
          S_RESP_LOW:  if (rise) begin state_d = S_RESP_HIGH; cnt_d = '0; end
          S_RESP_HIGH: if (fall) begin
            state_d   = S_BIT_LOW;
            cnt_d     = '0;
            bit_cnt_d = '0;
          end
          // the cycle in which the rise is seen counts as the first high cycle
          S_BIT_LOW:   if (rise) begin state_d = S_BIT_HIGH; cnt_d = CNT_W'(1); end
          S_BIT_HIGH:  if (fall) begin
            shift_d = {shift_q[38:0], bit_val};
            cnt_d   = '0;
            if (bit_cnt_q == 6'd39) begin
              state_d = S_DONE;
            end else begin
              state_d   = S_BIT_LOW;
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
          default: ;
        endcase
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (chk_ok) begin
          frame_d      = shift_q;
          data_valid_d = 1'b1;
        end else begin
          err_chk_d = 1'b1;
        end
      end
      S_ERROR: begin
        state_d       = S_IDLE;
        err_timeout_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE && state_q != S_IDLE) auto_d = AUTO_RELOAD;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_q       <= '0;
      sync_q        <= 3'b111;
      auto_q        <= AUTO_RELOAD;
      data_valid_q  <= 1'b0;
      err_timeout_q <= 1'b0;
      err_chk_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_q       <= frame_d;
      sync_q        <= sync_d;
      auto_q        <= auto_d;
      data_valid_q  <= data_valid_d;
      err_timeout_q <= err_timeout_d;
      err_chk_q     <= err_chk_d;
    end
  end

  assign DHT_data    = (state_q == S_START_LOW) ? 1'b0 : 1'bz;
  assign busy        = (state_q != S_IDLE);
  assign hum_int     = frame_q[39:32];
  assign hum_float   = frame_q[31:24];
  assign tmp_int     = frame_q[23:16];
  assign tmp_float   = frame_q[15:8];
  assign parity      = frame_q[7:0];
  assign data_valid  = data_valid_q;
  assign err_timeout = err_timeout_q;
  assign err_chk     = err_chk_q;

endmodule
`default_nettype wire

// File: tb/tb_dht_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht_reader
// Purpose  : Directed self-checking bench for dht_reader with a sensor model.
// Revision : 1.0
// ============================================================================
module tb_dht_reader;

  localparam logic [39:0] F1 = 40'h1A0B18003D;
  localparam logic [39:0] F2 = 40'h1A0B180033;
  localparam logic [39:0] F3 = 40'h3C050F80D0;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, sens_low = 1'b0;
  logic rst_a = 1'b1, start_a = 1'b0;
  wire  dht_line, auto_line;
  pullup (dht_line);
  pullup (auto_line);
  assign dht_line = sens_low ? 1'b0 : 1'bz;

  logic [7:0] hum_int, hum_float, tmp_int, tmp_float, parity;
  logic       data_valid, busy, err_timeout, err_chk;
  logic [7:0] hi_a, hf_a, ti_a, tf_a, par_a;
  logic       dv_a, busy_a, eto_a, ech_a;
  wire [39:0] frame_out;
  assign frame_out = {hum_int, hum_float, tmp_int, tmp_float, parity};

  int checks = 0, passes = 0, dv_cnt = 0, n, exp_dv;

  always #5 clk = ~clk;
  always @(posedge clk) if (data_valid) dv_cnt <= dv_cnt + 1;

  dht_reader #(.CLK_HZ(1_000_000), .START_US(1000)) u_dut (
    .CLK(clk), .RST(rst), .start(start), .DHT_data(dht_line),
    .hum_int(hum_int), .hum_float(hum_float), .tmp_int(tmp_int),
    .tmp_float(tmp_float), .parity(parity), .data_valid(data_valid),
    .busy(busy), .err_timeout(err_timeout), .err_chk(err_chk));

  dht_reader #(.CLK_HZ(1_000_000), .START_US(1000), .AUTO_PERIOD_MS(3)) u_auto (
    .CLK(clk), .RST(rst_a), .start(start_a), .DHT_data(auto_line),
    .hum_int(hi_a), .hum_float(hf_a), .tmp_int(ti_a),
    .tmp_float(tf_a), .parity(par_a), .data_valid(dv_a),
    .busy(busy_a), .err_timeout(eto_a), .err_chk(ech_a));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start, check the trigger response and the host low-pulse length.
  task automatic host_start();
    int low;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy, 1);
    chk("line_low", dht_line, 0);
    chk("err_clear", {err_timeout, err_chk}, 0);
    low = 0;
    while (dht_line === 1'b0 && low < 3000) begin
      low++;
      @(negedge clk);
    end
    chk("start_low_len", low, 1000);
  endtask

  // Sensor response and the first nbits bits of f; ends driving the line low.
  task automatic send_frame(input logic [39:0] f, input int h0, input int h1, input int nbits);
    repeat (20) @(negedge clk);
    sens_low = 1'b1; repeat (80) @(negedge clk);
    sens_low = 1'b0; repeat (80) @(negedge clk);
    for (int i = 39; i >= 40 - nbits; i--) begin
      sens_low = 1'b1; repeat (50) @(negedge clk);
      sens_low = 1'b0; repeat (f[i] ? h1 : h0) @(negedge clk);
    end
    sens_low = 1'b1;
  endtask

  task automatic txn(input string tag, input logic [39:0] f, input int h0, input int h1,
                     input logic exp_dv, input logic [39:0] exp_frame, input logic exp_chk);
    host_start();
    send_frame(f, h0, h1, 40);
    repeat (3) @(negedge clk);
    chk({tag, "_busy_hold"}, busy, 1);
    chk({tag, "_dv_early"}, data_valid, 0);
    @(negedge clk);
    chk({tag, "_dv"}, data_valid, exp_dv);
    chk({tag, "_busy_fall"}, busy, 0);
    chk({tag, "_frame"}, frame_out, exp_frame);
    chk({tag, "_err_chk"}, err_chk, exp_chk);
    chk({tag, "_err_to"}, err_timeout, 0);
    @(negedge clk);
    chk({tag, "_dv_once"}, data_valid, 0);
    repeat (50) @(negedge clk);
    sens_low = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_frame", frame_out, 0);
    chk("rst_flags", {data_valid, busy, err_timeout, err_chk}, 0);
    chk("rst_line", dht_line, 1);

    txn("t1", F1, 26, 70, 1'b1, F1, 1'b0);
    chk("t1_dv_count", dv_cnt, 1);

`ifdef DHT_CHECKSUM_EN
    txn("t2", F2, 26, 70, 1'b0, F1, 1'b1);
    exp_dv = 1;
`else
    txn("t2", F2, 26, 70, 1'b1, F2, 1'b0);
    exp_dv = 2;
`endif
    chk("t2_dv_count", dv_cnt, exp_dv);

    // 40 us high must decode 0, 41 us high must decode 1
    txn("t3", F3, 40, 41, 1'b1, F3, 1'b0);
    chk("t3_dv_count", dv_cnt, exp_dv + 1);

    // no sensor response after release
    host_start();
    repeat (201) @(negedge clk);
    chk("to_early", err_timeout, 0);
    chk("to_busy_hold", busy, 1);
    @(negedge clk);
    chk("to_flag", err_timeout, 1);
    chk("to_busy_fall", busy, 0);
    chk("to_line", dht_line, 1);
    chk("to_frame_kept", frame_out, F3);

    // reset during bit 20
    host_start();
    send_frame(F1, 26, 70, 20);
    repeat (10) @(negedge clk);
    chk("abort_busy", busy, 1);
    rst = 1'b1;
    sens_low = 1'b0;
    @(negedge clk);
    chk("abort_frame", frame_out, 0);
    chk("abort_flags", {data_valid, busy, err_timeout, err_chk}, 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // reset while the host drives the line low
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("startlow_line", dht_line, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_line", dht_line, 1);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    txn("t6", F1, 26, 70, 1'b1, F1, 1'b0);
    chk("t6_dv_count", dv_cnt, exp_dv + 2);

    // auto mode: no sensor, every transaction times out
    rst_a = 1'b0;
    n = 0;
    while (busy_a !== 1'b1 && n < 5000) begin n++; @(negedge clk); end
    chk("auto_first", busy_a, 1);
    for (int k = 0; k < 2; k++) begin
      if (k == 1) begin
        repeat (100) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
      end
      n = 0;
      while (busy_a === 1'b1 && n < 3000) begin n++; @(negedge clk); end
      chk("auto_done", {busy_a, eto_a}, 2'b01);
      n = 0;
      while (busy_a === 1'b0 && n < 5000) begin n++; @(negedge clk); end
      chk("auto_period", n, 3000);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
